// File: rtl/invsqrt_arbiter.sv
// Two-requester round-robin front end for a shared fixed-latency inverse-square-root core.
// A tag pipeline tracks which requester owns each in-flight result. A flush handshake quiesces the core.
module invsqrt_arbiter #(
    parameter int DATA_W  = 32,
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic [DATA_W-1:0] core_data_in,
    input  logic [DATA_W-1:0] core_data_out,
    input  logic              core_data_valid,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_data,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_data,
    input  logic              flush,
    output logic              flush_done,
    output logic              busy,
    output logic              err
);

    localparam int CNT_W = $clog2(LATENCY + 2);

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    state_t           state;
    logic             lastGrant;
    logic [LATENCY:0] tagValid;
    logic [LATENCY:0] tagId;
    logic [CNT_W-1:0] inFlight;
    logic             open;
    logic             grant0;
    logic             grant1;
    logic             xfer;
    logic             dueValid;
    logic             dueId;

    // Grants already include the valid, so a grant is a transfer.
    always_comb begin
        open     = (state == RUN) && !rst;
        grant0   = open && req0_valid && (!req1_valid || lastGrant);
        grant1   = open && req1_valid && (!req0_valid || !lastGrant);
        xfer     = grant0 || grant1;
        dueValid = tagValid[LATENCY];
        dueId    = tagId[LATENCY];
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign busy       = (inFlight != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            lastGrant    <= 1'b1;
            tagValid     <= '0;
            tagId        <= '0;
            inFlight     <= '0;
            core_data_in <= '0;
            rsp0_valid   <= 1'b0;
            rsp0_data    <= '0;
            rsp1_valid   <= 1'b0;
            rsp1_data    <= '0;
            flush_done   <= 1'b0;
            err          <= 1'b0;
        end else begin
            tagValid     <= {tagValid[LATENCY-1:0], xfer};
            tagId        <= {tagId[LATENCY-1:0], grant1};
            core_data_in <= grant1 ? req1_data : (grant0 ? req0_data : '0);
            if (xfer)
                lastGrant <= grant1;

            // The last tag stage lines up with the core output one cycle before delivery.
            rsp0_valid <= dueValid && !dueId;
            rsp1_valid <= dueValid && dueId;
            if (dueValid && !dueId)
                rsp0_data <= core_data_out;
            if (dueValid && dueId)
                rsp1_data <= core_data_out;
            if (dueValid && !core_data_valid)
                err <= 1'b1;

            case ({xfer, dueValid})
                2'b10:   inFlight <= inFlight + CNT_W'(1);
                2'b01:   inFlight <= inFlight - CNT_W'(1);
                default: inFlight <= inFlight;
            endcase

            case (state)
                RUN: begin
                    if (flush)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (inFlight == '0) begin
                        state      <= DONE;
                        flush_done <= 1'b1;
                    end
                end
                DONE: begin
                    if (!flush) begin
                        state      <= RUN;
                        flush_done <= 1'b0;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_invsqrt_arbiter.sv
// Scoreboard bench for invsqrt_arbiter with a 4-cycle stand-in core model.
// One operand value makes the model drop DataValid on its result slot.
module tb_invsqrt_arbiter;

    localparam int DATA_W  = 32;
    localparam int LATENCY = 4;
    localparam logic [31:0] MAGIC = 32'h41100000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req0_valid = 1'b0;
    logic [DATA_W-1:0] req0_data = '0;
    logic              req0_ready;
    logic              req1_valid = 1'b0;
    logic [DATA_W-1:0] req1_data = '0;
    logic              req1_ready;
    logic [DATA_W-1:0] core_data_in;
    logic [DATA_W-1:0] core_data_out;
    logic              core_data_valid;
    logic              rsp0_valid;
    logic [DATA_W-1:0] rsp0_data;
    logic              rsp1_valid;
    logic [DATA_W-1:0] rsp1_data;
    logic              flush = 1'b0;
    logic              flush_done;
    logic              busy;
    logic              err;

    invsqrt_arbiter #(.DATA_W(DATA_W), .LATENCY(LATENCY)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .core_data_in(core_data_in), .core_data_out(core_data_out),
        .core_data_valid(core_data_valid),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
        .flush(flush), .flush_done(flush_done), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] coreFn(input logic [31:0] x);
        if (x == 32'h40800000) return 32'h3F000000;
        return x ^ 32'h5A5A5A5A;
    endfunction

    // Core stand-in: not reset, so it keeps emitting across a DUT reset.
    logic [31:0] cd [LATENCY] = '{default: '0};
    logic        cv [LATENCY] = '{default: 1'b0};
    always @(posedge clk) begin
        cd[0] <= coreFn(core_data_in);
        cv[0] <= (core_data_in != 0) && (core_data_in != MAGIC);
        for (int i = 1; i < LATENCY; i++) begin
            cd[i] <= cd[i-1];
            cv[i] <= cv[i-1];
        end
    end
    assign core_data_out   = cd[LATENCY-1];
    assign core_data_valid = cv[LATENCY-1];

    int unsigned cycleNo = 0;
    always @(posedge clk) cycleNo <= cycleNo + 1;

    typedef struct {
        logic        id;
        logic [31:0] data;
        int unsigned due;
    } exp_t;
    exp_t sb[$];

    int  nPass = 0;
    int  nTotal = 0;
    logic tbLast = 1'b1;
    logic tbOpen = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTotal++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycleNo);
    endtask

    always @(negedge clk) begin
        if (rsp0_valid || rsp1_valid) begin
            if (rsp0_valid && rsp1_valid) begin
                nTotal++;
                $display("FAIL rsp_both: both response valids high (cycle %0d)", cycleNo);
            end else if (sb.size() == 0) begin
                nTotal++;
                $display("FAIL rsp_unexpected: got pulse id %0d expected none (cycle %0d)", rsp1_valid, cycleNo);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_id", {31'b0, rsp1_valid}, {31'b0, e.id});
                chk("rsp_data", rsp1_valid ? rsp1_data : rsp0_data, e.data);
                chk("rsp_cycle", cycleNo, e.due);
            end
        end
    end

    task automatic step(input logic v0, input logic [31:0] d0,
                        input logic v1, input logic [31:0] d1, input logic fl);
        logic e0, e1;
        @(negedge clk);
        req0_valid = v0; req0_data = d0;
        req1_valid = v1; req1_data = d1;
        flush = fl;
        #1;
        e0 = tbOpen && v0 && (!v1 || tbLast);
        e1 = tbOpen && v1 && (!v0 || !tbLast);
        chk("req0_ready", {31'b0, req0_ready}, {31'b0, e0});
        chk("req1_ready", {31'b0, req1_ready}, {31'b0, e1});
        if (e0) begin
            sb.push_back('{1'b0, coreFn(d0), cycleNo + LATENCY + 2});
            tbLast = 1'b0;
        end
        if (e1) begin
            sb.push_back('{1'b1, coreFn(d1), cycleNo + LATENCY + 2});
            tbLast = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) idle(1);
        chk("drain_timeout", sb.size(), 0);
    endtask

    initial begin
        int unsigned lastDue;
        logic done;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rsp0_valid", {31'b0, rsp0_valid}, 0);
        chk("rst_rsp1_valid", {31'b0, rsp1_valid}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_err", {31'b0, err}, 0);
        chk("rst_flush_done", {31'b0, flush_done}, 0);
        chk("rst_core_in", core_data_in, 0);
        rst = 1'b0;

        // Single op on channel 0.
        step(1'b1, 32'h40800000, 1'b0, '0, 1'b0);
        idle(1);
        chk("busy_single", {31'b0, busy}, 1);
        drain();
        chk("rsp0_data_4p0", rsp0_data, 32'h3F000000);

        // Channel 1 only, back-to-back.
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 32'h200 + i, 1'b0);
        idle(1);
        chk("busy_burst", {31'b0, busy}, 1);
        drain();
        chk("busy_after_burst", {31'b0, busy}, 0);

        // Both channels continuously: alternate starting with channel 0.
        for (int i = 1; i <= 8; i++) step(1'b1, i, 1'b1, 100 + i, 1'b0);
        drain();

        // Flush with ops in flight and requests pending.
        step(1'b1, 32'h301, 1'b0, '0, 1'b0);
        step(1'b1, 32'h302, 1'b0, '0, 1'b0);
        step(1'b1, 32'h303, 1'b1, 32'h304, 1'b1);
        lastDue = sb[$].due;
        tbOpen = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            step(1'b1, 32'h305, 1'b1, 32'h306, 1'b1);
            if (flush_done) begin
                done = 1'b1;
                chk("flush_done_cycle", cycleNo, lastDue + 1);
                chk("flush_done_empty", sb.size(), 0);
            end
        end
        chk("flush_done_seen", {31'b0, done}, 1);
        step(1'b1, 32'h307, 1'b0, '0, 1'b0);
        tbOpen = 1'b1;
        step(1'b1, 32'h308, 1'b0, '0, 1'b0);
        chk("flush_done_low", {31'b0, flush_done}, 0);
        drain();
        chk("err_clean", {31'b0, err}, 0);

        // Core drops DataValid on one result slot.
        step(1'b1, MAGIC, 1'b0, '0, 1'b0);
        drain();
        chk("err_set", {31'b0, err}, 1);
        idle(3);
        chk("err_sticky", {31'b0, err}, 1);

        // Reset while results are in flight.
        step(1'b1, 32'h401, 1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b1, 32'h402, 1'b0);
        idle(2);
        @(negedge clk);
        rst = 1'b1;
        sb.delete();
        tbLast = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle(10);
        chk("post_rst_busy", {31'b0, busy}, 0);
        chk("post_rst_err", {31'b0, err}, 0);
        step(1'b1, 32'h501, 1'b1, 32'h502, 1'b0);
        step(1'b1, 32'h503, 1'b1, 32'h504, 1'b0);
        drain();
        chk("final_busy", {31'b0, busy}, 0);

        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end

endmodule
